// File: rtl/async_fifo.sv
// async_fifo: 32 x 8 single-clock FIFO with registered read data and full/empty flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [WIDTH:0]          wptr_q, wptr_d;
    logic [WIDTH:0]          rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    do_write;
    logic                    do_read;

    // Pointers carry an extra wrap bit so equal addresses can be told apart as full or empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[WIDTH-1:0] == rptr_q[WIDTH-1:0]) && (wptr_q[WIDTH] != rptr_q[WIDTH]);

    assign do_write = wen && !full;
    assign do_read  = ren && !empty;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        data_out_d = data_out_q;
        if (do_write) begin
            wptr_d = wptr_q + {{WIDTH{1'b0}}, 1'b1};
        end
        if (do_read) begin
            rptr_d     = rptr_q + {{WIDTH{1'b0}}, 1'b1};
            data_out_d = mem_q[rptr_q[WIDTH-1:0]];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            data_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            data_out_q <= data_out_d;
        end
    end

    // NOTE: storage has no reset; resetting the pointers alone discards its contents logically.
    always_ff @(posedge wclk) begin
        if (do_write) begin
            mem_q[wptr_q[WIDTH-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set by any request the FIFO had to refuse, cleared only by reset.
    always_comb begin
        overflow_d  = overflow_q  || (wen && full);
        underflow_d = underflow_q || (ren && empty);
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed and randomized checks of async_fifo against a queue-based model.
// Compile with FIFO_ERR_FLAGS_EN to also check the sticky overflow/underflow outputs.
module tb_async_fifo;

    localparam int DEPTH = 32;

    logic       wclk    = 1'b0;
    logic       wrst    = 1'b0;
    logic       wen     = 1'b0;
    logic       ren     = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       full;
    logic       empty;
    logic [7:0] data_out;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a plain queue plus the expected registered output.
    logic [7:0] model_q [$];
    logic [7:0] exp_dout = 8'h00;
    logic       exp_ovf  = 1'b0;
    logic       exp_unf  = 1'b0;

    async_fifo #(.DATA_WIDTH(8), .WIDTH(5), .DEPTH(DEPTH)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .wen      (wen),
        .ren      (ren),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .data_out (data_out)
    );

    always #5 wclk = ~wclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle, advance the model by the FIFO rules, then sit 1 ns after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bit do_wr;
        bit do_rd;
        wen     = w;
        ren     = r;
        data_in = d;
        @(posedge wclk);
        do_rd = r && (model_q.size() > 0);
        do_wr = w && (model_q.size() < DEPTH);
        if (w && model_q.size() == DEPTH) exp_ovf = 1'b1;
        if (r && model_q.size() == 0)     exp_unf = 1'b1;
        if (do_rd) exp_dout = model_q.pop_front();
        if (do_wr) model_q.push_back(d);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({empty, full, data_out} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_during: got empty=%b full=%b dout=%h want 1 0 00", empty, full, data_out);
        end
        #1 wrst = 1'b1;
        #1;
        total++;
        if ({empty, full, data_out} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_after: got empty=%b full=%b dout=%h want 1 0 00", empty, full, data_out);
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++;
            $display("FAIL reset_errflags: got %b%b want 00", overflow, underflow);
        end
`endif
    endtask

    task automatic test_order();
        logic [7:0] vals [10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, vals[i]);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (data_out !== vals[i]) begin
                bad++;
                $display("FAIL order_data[%0d]: got %h want %h", i, data_out, vals[i]);
            end
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL order_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 8'($urandom_range(0, 254));
            step(1'b1, 1'b0, vals[i]);
            total++;
            if (full !== (i == DEPTH - 1)) begin
                bad++;
                $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH - 1));
            end
        end
        step(1'b1, 1'b0, 8'hFF);
        total++;
        if ({full, empty} !== 2'b10) begin
            bad++;
            $display("FAIL fill_drop_flags: got full=%b empty=%b want 1 0", full, empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL fill_overflow: got %b want 1", overflow);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (data_out !== vals[i]) begin
                bad++;
                $display("FAIL fill_data[%0d]: got %h want %h", i, data_out, vals[i]);
            end
        end
        total++;
        if ({full, empty} !== 2'b01) begin
            bad++;
            $display("FAIL fill_drained: got full=%b empty=%b want 0 1", full, empty);
        end
    endtask

    task automatic test_empty_read();
        logic [7:0] hold;
        hold = data_out;
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, empty} !== {hold, 1'b1}) begin
            bad++;
            $display("FAIL empty_read_hold: got dout=%h empty=%b want %h 1", data_out, empty, hold);
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if (underflow !== 1'b1) begin
            bad++;
            $display("FAIL empty_read_underflow: got %b want 1", underflow);
        end
`endif
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, empty} !== {8'h3C, 1'b1}) begin
            bad++;
            $display("FAIL empty_read_rptr: got dout=%h empty=%b want 3c 1", data_out, empty);
        end
    endtask

    task automatic test_simul_half();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 8'($urandom));
            total++;
            if ({data_out, full, empty} !== {exp_dout, 2'b00} || model_q.size() != 16) begin
                bad++;
                $display("FAIL simul_half[%0d]: got dout=%h full=%b empty=%b want %h 0 0",
                         i, data_out, full, empty, exp_dout);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (data_out !== exp_dout) begin
                bad++;
                $display("FAIL simul_half_drain[%0d]: got %h want %h", i, data_out, exp_dout);
            end
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] first;
        first = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i * 7 + 1));
            if (i == 0) first = 8'(i * 7 + 1);
        end
        step(1'b1, 1'b1, 8'hEE);
        total++;
        if ({data_out, full, empty} !== {first, 2'b00}) begin
            bad++;
            $display("FAIL simul_full: got dout=%h full=%b empty=%b want %h 0 0", data_out, full, empty, first);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total++;
            if (data_out !== exp_dout || data_out === 8'hEE) begin
                bad++;
                $display("FAIL simul_full_drain[%0d]: got %h want %h", i, data_out, exp_dout);
            end
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL simul_full_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_simul_empty();
        logic [7:0] hold;
        hold = data_out;
        step(1'b1, 1'b1, 8'h77);
        total++;
        if ({data_out, full, empty} !== {hold, 2'b00}) begin
            bad++;
            $display("FAIL simul_empty: got dout=%h full=%b empty=%b want %h 0 0", data_out, full, empty, hold);
        end
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, empty} !== {8'h77, 1'b1}) begin
            bad++;
            $display("FAIL simul_empty_read: got dout=%h empty=%b want 77 1", data_out, empty);
        end
    endtask

    task automatic test_random();
        int pw;
        int pr;
        for (int phase = 0; phase < 4; phase++) begin
            pw = (phase % 2 == 0) ? 80 : 25;
            pr = (phase % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
                total++;
                if ({data_out, full, empty} !==
                    {exp_dout, model_q.size() == DEPTH, model_q.size() == 0}) begin
                    bad++;
                    $display("FAIL random[%0d/%0d]: got dout=%h full=%b empty=%b want %h %b %b",
                             phase, i, data_out, full, empty, exp_dout,
                             model_q.size() == DEPTH, model_q.size() == 0);
                end
            end
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin
            bad++;
            $display("FAIL random_errflags: got %b%b want %b%b", overflow, underflow, exp_ovf, exp_unf);
        end
`endif
    endtask

    task automatic test_mid_reset();
        while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hA1 + i));
        step(1'b0, 1'b1, 8'h00);
        wrst = 1'b0;
        #1;
        total++;
        if ({empty, full, data_out} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL mid_reset: got empty=%b full=%b dout=%h want 1 0 00", empty, full, data_out);
        end
`ifdef FIFO_ERR_FLAGS_EN
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset_errflags: got %b%b want 00", overflow, underflow);
        end
`endif
        #1 wrst = 1'b1;
        model_reset();
        #1;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        total++;
        if ({data_out, empty} !== {8'h5A, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset_reuse: got dout=%h empty=%b want 5a 1", data_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fill();
        test_empty_read();
        test_simul_half();
        test_simul_full();
        test_simul_empty();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- 32-entry x 8-bit FIFO buffer on a single clock domain with asynchronous active-low reset.
- Decouples a byte producer (write side) from a byte consumer (read side) inside the same clock domain.
- Gives first-in-first-out ordering with registered read data and full/empty status flags.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of data_in/data_out.
- DEPTH, 32, number of storage entries; must equal 2**WIDTH.
- WIDTH, 5, address width; pointers are WIDTH+1 bits (extra wrap bit).

Ports:
- wclk  input  1  single clock for all logic; rising-edge.
- wrst  input  1  reset; one clock; reset is asynchronous and active-low (0 = reset asserted).
- wen  input  1  write enable, sampled on rising wclk.
- ren  input  1  read enable, sampled on rising wclk.
- full  output  1  high when DEPTH words are stored.
- empty  output  1  high when 0 words are stored.
- data_in  input  DATA_WIDTH  write data, captured with wen.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (wrst=0, asynchronous, no clock needed):
  - write pointer = 0, read pointer = 0, data_out = 0.
  - empty = 1, full = 0.
  - Memory contents are not cleared.
- Pointers: wptr and rptr, each WIDTH+1 bits (6 by default).
  - Address = low WIDTH bits; MSB is the wrap bit.
  - Both increment modulo 2**(WIDTH+1).
- Flags: combinational from the registered pointers, so they update in the same cycle the pointers change.
  - empty = (wptr == rptr).
  - full = (address bits equal) and (wrap bits differ).
- Write: on rising wclk with wen=1 and full=0:
  - mem[wptr addr] <= data_in; wptr += 1.
  - wen=1 while full is ignored; no pointer or memory change.
- Read: on rising wclk with ren=1 and empty=0:
  - data_out <= mem[rptr addr]; rptr += 1.
  - Data is valid after that edge (1-cycle latency).
  - ren=1 while empty is ignored; data_out holds its previous value.
  - data_out holds whenever no read occurs.
- Simultaneous wen and ren in one cycle:
  - Neither full nor empty: both operations occur; occupancy is unchanged; flags are unchanged.
  - Full: the read occurs, the write is blocked. full falls next cycle.
  - Empty: the write occurs, the read is blocked; no bypass of write data to data_out. empty falls next cycle.
- Wrap-around:
  - After the 32nd write, the address returns to 0 and the wrap bit toggles.
  - Ordering is preserved across any number of wraps.
- Reset asserted mid-operation: immediately returns to the reset state. Buffered data is discarded logically.
- Occupancy is always in the range 0..DEPTH; never corrupted by illegal requests.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs.
  - overflow (1 bit): sticky; set on a rising wclk where wen=1 and full=1.
  - underflow (1 bit): sticky; set on a rising wclk where ren=1 and empty=1.
  - Both are cleared only by reset (reset value 0). Blocked-request behaviour is otherwise unchanged.
- Not defined: the ports and logic are absent. The ignored-request behaviour above still applies.

Test Plan:
- Reset check: wrst=0 at t=0, then released -> empty=1, full=0, data_out=8'h00; no clock edge is needed for reset values.
- Order check: write 10 bytes (0x24, 0x81, 0x09, 0x63, 0x0D, 0x8D, 0x65, 0x12, 0x01, 0x0D), then read 10 -> data_out returns the same sequence, each value one cycle after its ren edge; empty=1 after the 10th read.
- Fill to full: 32 consecutive writes -> full=1 after the 32nd edge. A 33rd write of 0xFF is dropped. Reading 32 words returns the original 32; 0xFF never appears. With FIFO_ERR_FLAGS_EN defined, overflow=1.
- Empty read: ren=1 with empty=1 -> data_out holds its last value and rptr is unchanged. With FIFO_ERR_FLAGS_EN defined, underflow=1.
- Simultaneous operations:
  - Half-full (16 words) with wen=ren=1 for 40 cycles -> occupancy stays 16; full=0 and empty=0 throughout; ordering is preserved across pointer wrap.
  - Full with wen=ren=1 -> only the read occurs.
  - Empty with wen=ren=1 -> only the write occurs.
- Mid-operation reset: 5 words stored, pulse wrst=0 between clock edges -> empty=1 and data_out=0 immediately. A subsequent write then read of 0x5A returns 0x5A.
